// File: rtl/usb_rx_destuff.sv
// USB receive path: NRZI decode, bit destuffing, byte assembly and packet verdict.
// Optional CRC16 checking is built when the macro RX_CRC_CHECK_EN is defined;
// otherwise the packet verdict only checks byte alignment and a non-empty packet.
module usb_rx_destuff #(
    parameter int unsigned STUFF_LIMIT = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       bit_strobe,
    input  logic       d_in,
    input  logic       eop,
    output logic [7:0] rx_data,
    output logic       byte_ready,
    output logic       pkt_done,
    output logic       crc_ok,
    output logic       stuff_err,
    output logic       busy
);

    localparam int unsigned OnesW = $clog2(STUFF_LIMIT + 1);
    localparam logic [OnesW-1:0] OnesLimit = OnesW'(STUFF_LIMIT);

    typedef enum logic [1:0] {StIdle, StRecv, StDone, StErr} state_e;

    state_e           state_q, state_d;
    logic             prev_level;
    logic [OnesW-1:0] ones_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       byte_cnt;
    logic [6:0]       shift;

    logic in_recv, dec_bit, at_limit;
    logic bit_evt, take_bit, drop_bit, viol, eop_evt;
    logic verdict;

    // Qualified events; start always overrides, eop overrides a same-cycle bit.
    always_comb begin
        in_recv  = (state_q == StRecv);
        dec_bit  = (d_in == prev_level);
        at_limit = (ones_cnt == OnesLimit);
        bit_evt  = in_recv && bit_strobe && !eop && !start;
        take_bit = bit_evt && !at_limit;
        drop_bit = bit_evt && at_limit && !dec_bit;
        viol     = bit_evt && at_limit && dec_bit;
        eop_evt  = in_recv && eop && !start;
    end

`ifdef RX_CRC_CHECK_EN
    logic [15:0] crc;
    logic        crc_fb;

    // CRC16 over every accepted bit after the PID byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= 16'hFFFF;
        end else if (start) begin
            crc <= 16'hFFFF;
        end else if (take_bit && (byte_cnt != 8'd0)) begin
            crc <= {crc[14:0], 1'b0} ^ (crc_fb ? 16'h8005 : 16'h0000);
        end
    end

    // Residual check plus byte alignment and minimum PID + CRC length.
    always_comb begin
        crc_fb  = crc[15] ^ dec_bit;
        verdict = (crc == 16'h800D) && (bit_cnt == 3'd0) && (byte_cnt >= 8'd3);
    end
`else
    // Without CRC the verdict is alignment and at least one complete byte.
    always_comb begin
        verdict = (bit_cnt == 3'd0) && (byte_cnt >= 8'd1);
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = StRecv;
        end else begin
            unique case (state_q)
                StRecv: begin
                    if (eop_evt) begin
                        state_d = StDone;
                    end else if (viol) begin
                        state_d = StErr;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = state_q;
            endcase
        end
    end

    // FSM-decoded outputs.
    always_comb begin
        busy     = (state_q == StRecv);
        pkt_done = (state_q == StDone);
    end

    // Decode, destuff, byte assembly and sticky status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_level <= 1'b0;
            ones_cnt   <= '0;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 8'd0;
            shift      <= 7'd0;
            rx_data    <= 8'd0;
            byte_ready <= 1'b0;
            crc_ok     <= 1'b0;
            stuff_err  <= 1'b0;
        end else begin
            byte_ready <= 1'b0;
            if (start) begin
                // Last SYNC symbol is K, so the first data bit decodes against 0.
                prev_level <= 1'b0;
                ones_cnt   <= '0;
                bit_cnt    <= 3'd0;
                byte_cnt   <= 8'd0;
                crc_ok     <= 1'b0;
                stuff_err  <= 1'b0;
            end else begin
                if (eop_evt) begin
                    crc_ok <= verdict;
                end
                if (bit_evt) begin
                    prev_level <= d_in;
                end
                if (drop_bit) begin
                    ones_cnt <= '0;
                end
                if (viol) begin
                    stuff_err <= 1'b1;
                end
                if (take_bit) begin
                    shift    <= {dec_bit, shift[6:1]};
                    ones_cnt <= dec_bit ? ones_cnt + 1'b1 : '0;
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_data    <= {dec_bit, shift};
                        byte_ready <= 1'b1;
                        if (byte_cnt != 8'hFF) begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_destuff.sv
// Directed bench for usb_rx_destuff: a table of whole packets plus hand-written
// sequences for stuffing, stuff violation, reset, restart and eop races.
module tb_usb_rx_destuff;

`ifdef RX_CRC_CHECK_EN
    localparam bit CrcEn = 1'b1;
`else
    localparam bit CrcEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       bit_strobe = 1'b0;
    logic       d_in = 1'b0;
    logic       eop = 1'b0;
    logic [7:0] rx_data;
    logic       byte_ready, pkt_done, crc_ok, stuff_err, busy;

    usb_rx_destuff #(.STUFF_LIMIT(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bit_strobe (bit_strobe),
        .d_in       (d_in),
        .eop        (eop),
        .rx_data    (rx_data),
        .byte_ready (byte_ready),
        .pkt_done   (pkt_done),
        .crc_ok     (crc_ok),
        .stuff_err  (stuff_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int n_br   = 0;
    int n_pd   = 0;
    logic [7:0] got [8];
    logic line_lvl = 1'b0;
    int   ones     = 0;

    typedef struct {
        string       name;
        logic [31:0] bytes;
        int          nb;
        int          extra;
        logic        exp_ok;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock; sample outputs 1 time unit after the edge and log pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (byte_ready) begin
            if (n_br < 8) got[n_br] = rx_data;
            n_br++;
        end
        if (pkt_done) n_pd++;
    endtask

    task automatic send_line_bit(input logic lvl);
        d_in       = lvl;
        bit_strobe = 1'b1;
        tick();
        bit_strobe = 1'b0;
        tick();
    endtask

    // Transmitter model: bit stuffing after six 1s, then NRZI encoding.
    task automatic send_data_bit(input logic b);
        if (!b) line_lvl = ~line_lvl;
        send_line_bit(line_lvl);
        ones = b ? ones + 1 : 0;
        if (ones == 6) begin
            line_lvl = ~line_lvl;
            send_line_bit(line_lvl);
            ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 8; k++) send_data_bit(b[k]);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start    = 1'b0;
        line_lvl = 1'b0;
        ones     = 0;
        n_br     = 0;
        n_pd     = 0;
    endtask

    task automatic do_eop();
        eop = 1'b1;
        tick();
        eop = 1'b0;
        tick();
    endtask

    task automatic run_packet(input string name, input logic [31:0] bytes, input int nb,
                              input int extra, input logic exp_ok);
        do_start();
        for (int j = 0; j < nb; j++) send_byte(bytes[8*j +: 8]);
        for (int k = 0; k < extra; k++) send_data_bit(1'b0);
        do_eop();
        check({name, " byte_ready count"}, n_br, nb);
        for (int j = 0; j < nb; j++) check({name, " rx_data"}, got[j], bytes[8*j +: 8]);
        check({name, " pkt_done count"}, n_pd, 1);
        check({name, " crc_ok"}, crc_ok, exp_ok);
    endtask

    initial begin
        vecs[0] = '{"data0_empty", 32'h0000_00C3, 3, 0, 1'b1};
        vecs[1] = '{"data0_bad_crc", 32'h0001_00C3, 3, 0, !CrcEn};
        vecs[2] = '{"misaligned", 32'h0000_00C3, 1, 5, 1'b0};
        vecs[3] = '{"pid_only", 32'h0000_00C3, 1, 0, !CrcEn};
        vecs[4] = '{"pid_ff_stuffed", 32'h0000_FFC3, 2, 0, !CrcEn};

        // Reset state.
        #1;
        check("reset outputs", {rx_data, byte_ready, pkt_done, crc_ok, stuff_err, busy}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("idle after reset busy", busy, 0);

        for (int i = 0; i < 5; i++) begin
            run_packet(vecs[i].name, vecs[i].bytes, vecs[i].nb, vecs[i].extra, vecs[i].exp_ok);
        end

        // 0xFF with a stuffed 0 after six 1s: byte completes on the 9th strobe.
        do_start();
        for (int k = 0; k < 6; k++) send_line_bit(1'b0);
        send_line_bit(1'b1);
        send_line_bit(1'b1);
        check("stuff ff after 8 strobes", n_br, 0);
        send_line_bit(1'b1);
        check("stuff ff after 9 strobes", n_br, 1);
        check("stuff ff rx_data", got[0], 8'hFF);
        check("stuff ff stuff_err", stuff_err, 0);
        do_eop();
        check("stuff ff pkt_done", n_pd, 1);

        // Seven decoded 1s: violation on the 7th strobe, then ERR ignores eop.
        do_start();
        for (int k = 0; k < 6; k++) send_line_bit(1'b0);
        check("viol before 7th", stuff_err, 0);
        send_line_bit(1'b0);
        check("viol stuff_err", stuff_err, 1);
        check("viol left recv", busy, 0);
        do_eop();
        check("viol no pkt_done", n_pd, 0);
        check("viol no byte_ready", n_br, 0);
        do_start();
        check("restart clears stuff_err", stuff_err, 0);
        check("restart busy", busy, 1);

        // Asynchronous reset mid second byte.
        do_start();
        send_byte(8'hC3);
        for (int k = 0; k < 4; k++) send_data_bit(1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async reset outputs",
              {rx_data, byte_ready, pkt_done, crc_ok, stuff_err, busy}, 0);
        @(negedge clk);
        rst  = 1'b0;
        n_br = 0;
        n_pd = 0;
        send_line_bit(1'b0);
        do_eop();
        check("post reset idle pulses", n_br + n_pd, 0);
        check("post reset busy", busy, 0);
        run_packet("after_reset", 32'h0000_00C3, 3, 0, 1'b1);

        // start with eop in RECV: start wins and the partial byte is dropped.
        do_start();
        for (int k = 0; k < 3; k++) send_data_bit(1'b1);
        start = 1'b1;
        eop   = 1'b1;
        tick();
        start    = 1'b0;
        eop      = 1'b0;
        line_lvl = 1'b0;
        ones     = 0;
        tick();
        check("start beats eop busy", busy, 1);
        check("start beats eop pulses", n_br + n_pd, 0);
        for (int j = 0; j < 3; j++) send_byte(8'(32'h0000_00C3 >> (8 * j)));
        do_eop();
        check("restart packet bytes", n_br, 3);
        check("restart packet crc_ok", crc_ok, 1);

        // eop with a same-cycle strobe: the bit must not disturb alignment.
        do_start();
        for (int j = 0; j < 3; j++) send_byte(8'(32'h0000_00C3 >> (8 * j)));
        eop        = 1'b1;
        bit_strobe = 1'b1;
        d_in       = ~line_lvl;
        tick();
        eop        = 1'b0;
        bit_strobe = 1'b0;
        tick();
        check("eop+strobe pkt_done", n_pd, 1);
        check("eop+strobe crc_ok", crc_ok, 1);
        check("eop+strobe byte count", n_br, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
